// File: rtl/rocket_pool_controller.sv
// Pool of projectile slots with fixed-point motion, fire arbitration,
// border retirement and collision kill.
module rocket_pool_controller #(
    parameter int NUM_ROCKETS   = 4,
    parameter int FRAC_BITS     = 6,
    parameter int COORD_W       = 11,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int ROCKET_W      = 16,
    parameter int ROCKET_H      = 16,
    parameter int FIRE_COOLDOWN = 3,
    localparam int SW = (NUM_ROCKETS > 1) ? $clog2(NUM_ROCKETS) : 1
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           fireReq,
    input  logic [COORD_W-1:0]             fireX,
    input  logic [COORD_W-1:0]             fireY,
    input  logic [COORD_W-1:0]             fireSpeedX,
    input  logic [COORD_W-1:0]             fireSpeedY,
    input  logic [NUM_ROCKETS-1:0]         hitVector,
    output logic                           fireAck,
    output logic                           fireDrop,
    output logic [SW-1:0]                  fireSlot,
    output logic [NUM_ROCKETS-1:0]         activeVector,
    output logic [NUM_ROCKETS*COORD_W-1:0] topLeftXFlat,
    output logic [NUM_ROCKETS*COORD_W-1:0] topLeftYFlat,
    output logic [NUM_ROCKETS-1:0]         sideToFace,
    output logic [NUM_ROCKETS-1:0]         borderPulse
);

    localparam int PW = COORD_W + FRAC_BITS + 2;
    localparam int CW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam logic signed [PW-1:0] L_XMAX = PW'(SCREEN_W - ROCKET_W);
    localparam logic signed [PW-1:0] L_YMAX = PW'(SCREEN_H - ROCKET_H);

    logic signed [PW-1:0]      r_posX [NUM_ROCKETS];
    logic signed [PW-1:0]      r_posY [NUM_ROCKETS];
    logic        [COORD_W-1:0] r_spdX [NUM_ROCKETS];
    logic        [COORD_W-1:0] r_spdY [NUM_ROCKETS];
    logic [NUM_ROCKETS-1:0]    r_active;
    logic [NUM_ROCKETS-1:0]    r_border;
    logic [CW-1:0]             r_cool;
    logic                      r_ack;
    logic                      r_drop;
    logic [SW-1:0]             r_slot;

    logic signed [PW-1:0] w_nx  [NUM_ROCKETS];
    logic signed [PW-1:0] w_ny  [NUM_ROCKETS];
    logic signed [PW-1:0] w_pxX [NUM_ROCKETS];
    logic signed [PW-1:0] w_pxY [NUM_ROCKETS];
    logic [NUM_ROCKETS-1:0] w_out;
    logic [SW-1:0]          w_sel;
    logic                   w_accept;

    // Lowest-index free slot, taken from registered state only
    always_comb begin
        w_sel = '0;
        for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
            if (!r_active[i]) w_sel = SW'(i);
        end
    end

    assign w_accept = fireReq && (r_cool == '0) && !(&r_active);

    always_comb begin
        w_out = '0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            w_nx[i]  = r_posX[i] +
                       {{(PW-COORD_W){r_spdX[i][COORD_W-1]}}, r_spdX[i]};
            w_ny[i]  = r_posY[i] +
                       {{(PW-COORD_W){r_spdY[i][COORD_W-1]}}, r_spdY[i]};
            w_pxX[i] = w_nx[i] >>> FRAC_BITS;
            w_pxY[i] = w_ny[i] >>> FRAC_BITS;
            w_out[i] = w_pxX[i][PW-1] || (w_pxX[i] > L_XMAX) ||
                       w_pxY[i][PW-1] || (w_pxY[i] > L_YMAX);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_active <= '0;
            r_border <= '0;
            r_cool   <= '0;
            r_ack    <= 1'b0;
            r_drop   <= 1'b0;
            r_slot   <= '0;
            for (int i = 0; i < NUM_ROCKETS; i++) begin
                r_posX[i] <= '0;
                r_posY[i] <= '0;
                r_spdX[i] <= '0;
                r_spdY[i] <= '0;
            end
        end else begin
            r_ack    <= w_accept;
            r_drop   <= fireReq && !w_accept;
            r_border <= '0;
            if (w_accept) begin
                r_slot <= w_sel;
                r_cool <= CW'(FIRE_COOLDOWN);
            end else if (startOfFrame && (r_cool != '0)) begin
                r_cool <= r_cool - 1'b1;
            end
            for (int i = 0; i < NUM_ROCKETS; i++) begin
                if (r_active[i] && hitVector[i]) begin
                    r_active[i] <= 1'b0;
                end else if (w_accept && (w_sel == SW'(i))) begin
                    r_active[i] <= 1'b1;
                    r_posX[i]   <= {{2{fireX[COORD_W-1]}}, fireX,
                                    {FRAC_BITS{1'b0}}};
                    r_posY[i]   <= {{2{fireY[COORD_W-1]}}, fireY,
                                    {FRAC_BITS{1'b0}}};
                    r_spdX[i]   <= fireSpeedX;
                    r_spdY[i]   <= fireSpeedY;
                end else if (r_active[i] && startOfFrame) begin
                    // Updated position is kept even when retiring
                    r_posX[i] <= w_nx[i];
                    r_posY[i] <= w_ny[i];
                    if (w_out[i]) begin
                        r_active[i] <= 1'b0;
                        r_border[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        topLeftXFlat = '0;
        topLeftYFlat = '0;
        sideToFace   = '0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            topLeftXFlat[i*COORD_W +: COORD_W] = r_posX[i][FRAC_BITS +: COORD_W];
            topLeftYFlat[i*COORD_W +: COORD_W] = r_posY[i][FRAC_BITS +: COORD_W];
            sideToFace[i] = r_spdX[i][COORD_W-1];
        end
    end

    assign fireAck      = r_ack;
    assign fireDrop     = r_drop;
    assign fireSlot     = r_slot;
    assign activeVector = r_active;
    assign borderPulse  = r_border;

endmodule

// File: tb/tb_rocket_pool_controller.sv
// Directed bench for rocket_pool_controller: one instance without
// cooldown, one with FIRE_COOLDOWN=3, sharing the same stimulus.
module tb_rocket_pool_controller;

    logic        clk;
    logic        resetN;
    logic        sof;
    logic        fireReq;
    logic [10:0] fx, fy, fsx, fsy;
    logic [3:0]  hit;

    logic        ack0, drop0, ack3, drop3;
    logic [1:0]  slot0, slot3;
    logic [3:0]  act0, act3, side0, side3, bord0, bord3;
    logic [43:0] xf0, yf0, xf3, yf3;

    int checks = 0;
    int failures = 0;

    rocket_pool_controller #(.FIRE_COOLDOWN(0)) u_dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .fireReq(fireReq), .fireX(fx), .fireY(fy),
        .fireSpeedX(fsx), .fireSpeedY(fsy), .hitVector(hit),
        .fireAck(ack0), .fireDrop(drop0), .fireSlot(slot0),
        .activeVector(act0), .topLeftXFlat(xf0), .topLeftYFlat(yf0),
        .sideToFace(side0), .borderPulse(bord0)
    );

    rocket_pool_controller #(.FIRE_COOLDOWN(3)) u_dut3 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .fireReq(fireReq), .fireX(fx), .fireY(fy),
        .fireSpeedX(fsx), .fireSpeedY(fsy), .hitVector(hit),
        .fireAck(ack3), .fireDrop(drop3), .fireSlot(slot3),
        .activeVector(act3), .topLeftXFlat(xf3), .topLeftYFlat(yf3),
        .sideToFace(side3), .borderPulse(bord3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic signed [10:0] px(input logic [43:0] f,
                                              input int s);
        return f[s*11 +: 11];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fireReq = 0; sof = 0; hit = '0;
        resetN = 0;
        cyc(); cyc();
        resetN = 1;
        cyc();
    endtask

    task automatic fire(input int x, input int y,
                        input int sx, input int sy);
        fx = 11'(x); fy = 11'(y); fsx = 11'(sx); fsy = 11'(sy);
        fireReq = 1;
        cyc();
        fireReq = 0;
    endtask

    task automatic frame();
        sof = 1;
        cyc();
        sof = 0;
    endtask

    task automatic test_reset();
        resetN = 0; hit = '0;
        fx = 11'd5; fy = 11'd5; fsx = 11'd1; fsy = 11'd1;
        fireReq = 0; sof = 0;
        for (int k = 0; k < 4; k++) begin
            fireReq = ~fireReq;
            sof = ~sof;
            cyc();
            checks++;
            if ({ack0, drop0, slot0, act0, xf0, yf0, side0, bord0} !== '0) begin
                failures++;
                $display("FAIL reset_outs0 cyc=%0d act=%b ack=%b drop=%b", k, act0, ack0, drop0);
            end
            checks++;
            if ({ack3, drop3, slot3, act3, xf3, yf3, side3, bord3} !== '0) begin
                failures++;
                $display("FAIL reset_outs3 cyc=%0d act=%b ack=%b drop=%b", k, act3, ack3, drop3);
            end
        end
        fireReq = 0; sof = 0;
        resetN = 1;
        cyc();
        checks++;
        if ({act0, act3} !== 8'h00) begin
            failures++;
            $display("FAIL reset_release act0=%b act3=%b exp=0000", act0, act3);
        end
    endtask

    task automatic test_motion();
        do_reset();
        fire(100, 200, 128, -64);
        checks++;
        if ({ack0, drop0, slot0, act0} !== {1'b1, 1'b0, 2'd0, 4'b0001}) begin
            failures++;
            $display("FAIL motion_fire ack=%b drop=%b slot=%0d act=%b exp 1 0 0 0001", ack0, drop0, slot0, act0);
        end
        checks++;
        if (px(xf0, 0) !== 11'sd100 || px(yf0, 0) !== 11'sd200) begin
            failures++;
            $display("FAIL motion_load x=%0d y=%0d exp 100 200", px(xf0, 0), px(yf0, 0));
        end
        frame();
        checks++;
        if (ack0 !== 1'b0) begin
            failures++;
            $display("FAIL motion_ack_pulse ack=%b exp=0", ack0);
        end
        checks++;
        if (px(xf0, 0) !== 11'sd102 || px(yf0, 0) !== 11'sd199) begin
            failures++;
            $display("FAIL motion_f1 x=%0d y=%0d exp 102 199", px(xf0, 0), px(yf0, 0));
        end
        frame();
        checks++;
        if (px(xf0, 0) !== 11'sd104 || px(yf0, 0) !== 11'sd198 || side0[0] !== 1'b0) begin
            failures++;
            $display("FAIL motion_f2 x=%0d y=%0d side=%b exp 104 198 0", px(xf0, 0), px(yf0, 0), side0[0]);
        end
    endtask

    task automatic test_pool();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fire(100 + 20 * k, 100, 0, 0);
            checks++;
            if (ack0 !== 1'b1 || slot0 !== 2'(k)) begin
                failures++;
                $display("FAIL pool_fire%0d ack=%b slot=%0d exp 1 %0d", k, ack0, slot0, k);
            end
        end
        checks++;
        if (act0 !== 4'b1111) begin
            failures++;
            $display("FAIL pool_full act=%b exp=1111", act0);
        end
        fire(300, 300, 5, 5);
        checks++;
        if ({ack0, drop0, slot0, act0} !== {1'b0, 1'b1, 2'd3, 4'b1111}) begin
            failures++;
            $display("FAIL pool_drop ack=%b drop=%b slot=%0d act=%b exp 0 1 3 1111", ack0, drop0, slot0, act0);
        end
        checks++;
        if (px(xf0, 1) !== 11'sd120 || px(xf0, 3) !== 11'sd160) begin
            failures++;
            $display("FAIL pool_nochange x1=%0d x3=%0d exp 120 160", px(xf0, 1), px(xf0, 3));
        end
        hit = 4'b0010;
        cyc();
        hit = '0;
        checks++;
        if (act0 !== 4'b1101 || bord0 !== 4'b0000 || drop0 !== 1'b0) begin
            failures++;
            $display("FAIL pool_hit act=%b bord=%b drop=%b exp 1101 0000 0", act0, bord0, drop0);
        end
        fire(50, 50, 0, 0);
        checks++;
        if (ack0 !== 1'b1 || slot0 !== 2'd1 || act0 !== 4'b1111) begin
            failures++;
            $display("FAIL pool_refire ack=%b slot=%0d act=%b exp 1 1 1111", ack0, slot0, act0);
        end
    endtask

    task automatic test_border();
        do_reset();
        fire(620, 100, 512, 0);
        frame();
        checks++;
        if (bord0 !== 4'b0001 || act0[0] !== 1'b0 || px(xf0, 0) !== 11'sd628) begin
            failures++;
            $display("FAIL border_right bord=%b act=%b x=%0d exp 0001 0 628", bord0, act0, px(xf0, 0));
        end
        cyc();
        checks++;
        if (bord0 !== 4'b0000 || px(xf0, 0) !== 11'sd628) begin
            failures++;
            $display("FAIL border_pulse bord=%b x=%0d exp 0000 628", bord0, px(xf0, 0));
        end
        fire(0, 100, -64, 0);
        checks++;
        if (ack0 !== 1'b1 || slot0 !== 2'd0 || side0[0] !== 1'b1) begin
            failures++;
            $display("FAIL border_left_fire ack=%b slot=%0d side=%b exp 1 0 1", ack0, slot0, side0[0]);
        end
        frame();
        checks++;
        if (bord0 !== 4'b0001 || act0[0] !== 1'b0 || px(xf0, 0) !== -11'sd1) begin
            failures++;
            $display("FAIL border_left bord=%b act=%b x=%0d exp 0001 0 -1", bord0, act0, px(xf0, 0));
        end
        fire(100, 470, 0, 64);
        frame();
        checks++;
        if (bord0 !== 4'b0001 || px(yf0, 0) !== 11'sd471) begin
            failures++;
            $display("FAIL border_bottom bord=%b y=%0d exp 0001 471", bord0, px(yf0, 0));
        end
        fire(624, 464, 0, 0);
        frame();
        checks++;
        if (bord0 !== 4'b0000 || act0[0] !== 1'b1) begin
            failures++;
            $display("FAIL border_edge_stay bord=%b act=%b exp 0000 1", bord0, act0);
        end
    endtask

    task automatic test_cooldown();
        do_reset();
        fire(100, 100, 0, 0);
        checks++;
        if (ack3 !== 1'b1 || slot3 !== 2'd0) begin
            failures++;
            $display("FAIL cool_first ack=%b slot=%0d exp 1 0", ack3, slot3);
        end
        for (int k = 0; k < 3; k++) begin
            fire(100, 100, 0, 0);
            checks++;
            if (ack3 !== 1'b0 || drop3 !== 1'b1 || act3 !== 4'b0001) begin
                failures++;
                $display("FAIL cool_drop%0d ack=%b drop=%b act=%b exp 0 1 0001", k, ack3, drop3, act3);
            end
            frame();
        end
        fire(100, 100, 0, 0);
        checks++;
        if (ack3 !== 1'b1 || drop3 !== 1'b0 || slot3 !== 2'd1) begin
            failures++;
            $display("FAIL cool_after ack=%b drop=%b slot=%0d exp 1 0 1", ack3, drop3, slot3);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sof = 1;
        fire(50, 60, 64, 64);
        sof = 0;
        checks++;
        if (ack0 !== 1'b1 || px(xf0, 0) !== 11'sd50 || px(yf0, 0) !== 11'sd60) begin
            failures++;
            $display("FAIL simul_load ack=%b x=%0d y=%0d exp 1 50 60", ack0, px(xf0, 0), px(yf0, 0));
        end
        frame();
        checks++;
        if (px(xf0, 0) !== 11'sd51 || px(yf0, 0) !== 11'sd61) begin
            failures++;
            $display("FAIL simul_move x=%0d y=%0d exp 51 61", px(xf0, 0), px(yf0, 0));
        end
        for (int k = 1; k < 4; k++) fire(200, 200, 0, 0);
        hit = 4'b0100;
        fire(300, 300, 0, 0);
        hit = '0;
        checks++;
        if (drop0 !== 1'b1 || ack0 !== 1'b0 || act0 !== 4'b1011) begin
            failures++;
            $display("FAIL simul_hit_fire drop=%b ack=%b act=%b exp 1 0 1011", drop0, ack0, act0);
        end
        fire(300, 300, 0, 0);
        checks++;
        if (ack0 !== 1'b1 || slot0 !== 2'd2 || act0 !== 4'b1111) begin
            failures++;
            $display("FAIL simul_refire ack=%b slot=%0d act=%b exp 1 2 1111", ack0, slot0, act0);
        end
        #3;
        resetN = 0;
        #1;
        checks++;
        if (act0 !== 4'b0000 || xf0 !== '0 || ack0 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset act=%b ack=%b exp 0000 0", act0, ack0);
        end
        resetN = 1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_motion();
        test_pool();
        test_border();
        test_cooldown();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
